ir_button_events: RTL and testbench

Converts validated 32-bit NEC infrared frames from the IR receive stage into button events for the game logic. Sits directly downstream of the IR synchronizer/decoder wrapper and consumes its code word plus new-code strobe. The block:
- checks address and inverse bytes,
- tracks key hold using NEC repeat frames,
- emits press, auto-repeat and release pulses plus a held level.

---
 rtl/ir_button_events.sv | 186 ++++++++++++++++++
 tb/tb_ir_button_events.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_button_events.sv
// ir_button_events
//   Turns validated 32-bit NEC infrared frames into button events for the game
//   logic. The block checks the address and inverse bytes, tracks a held key
//   through NEC repeat frames, and produces press, auto-repeat and release
//   pulses plus a held level.
//
// Ports
//   clk_in         system clock
//   rst_in         synchronous active-high reset
//   code_in        NEC frame {addr, ~addr, cmd, ~cmd}
//   code_valid_in  one-cycle strobe, code_in valid
//   repeat_in      one-cycle strobe, NEC repeat frame seen
//   cmd_out        command of the current or last key
//   press_out      one-cycle pulse on a new key press
//   repeat_out     one-cycle auto-repeat pulse while held
//   release_out    one-cycle pulse when the held key ends (cmd_out = old key)
//   held_out       high while a key is held
//   err_out        one-cycle error code: 01 inverse mismatch, 10 address mismatch
//   err_count_out  rejected-frame count, saturating at 8'hFF
module ir_button_events #(
  parameter logic [7:0] ADDRESS       = 8'h00,
  parameter int         HOLD_CYCLES   = 11_000_000,
  parameter int         REPEAT_DELAY  = 40_000_000,
  parameter int         REPEAT_PERIOD = 10_000_000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] code_in,
  input  logic        code_valid_in,
  input  logic        repeat_in,
  output logic [7:0]  cmd_out,
  output logic        press_out,
  output logic        repeat_out,
  output logic        release_out,
  output logic        held_out,
  output logic [1:0]  err_out,
  output logic [7:0]  err_count_out
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW   = $clog2(HOLD_CYCLES + 1);
  localparam int RW   = $clog2(RMAX + 1);

  // Timers are loaded with N-1: the load happens on the edge that also
  // registers the triggering pulse, so expiry at 0 lands the next event
  // exactly N cycles after that pulse.
  localparam int HOLD_LD_I  = HOLD_CYCLES - 1;
  localparam int DELAY_LD_I = REPEAT_DELAY - 1;
  localparam int PER_LD_I   = REPEAT_PERIOD - 1;
  localparam logic [HW-1:0] HOLD_LD  = HOLD_LD_I[HW-1:0];
  localparam logic [RW-1:0] DELAY_LD = DELAY_LD_I[RW-1:0];
  localparam logic [RW-1:0] PER_LD   = PER_LD_I[RW-1:0];

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_HELD      = 2'd1,
    S_REPEATING = 2'd2,
    S_SWITCH    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [RW-1:0]   rpt_q, rpt_d;     // delay timer in HELD, period timer in REPEATING
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      pend_q, pend_d;   // new command waiting in SWITCH
  logic            press_q, press_d;
  logic            repeat_q, repeat_d;
  logic            release_q, release_d;
  logic            held_q, held_d;
  logic [1:0]      err_q, err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;

  logic inv_ok, addr_ok, frame_ok, frame_bad, refresh_rep;
  logic [7:0] frame_cmd;

  assign frame_cmd   = code_in[15:8];
  assign inv_ok      = (code_in[31:24] == ~code_in[23:16]) &&
                       (code_in[15:8]  == ~code_in[7:0]);
  assign addr_ok     = (code_in[31:24] == ADDRESS);
  assign frame_ok    = code_valid_in && inv_ok && addr_ok;
  assign frame_bad   = code_valid_in && !(inv_ok && addr_ok);
  // A repeat strobe alongside a frame strobe is dropped; the frame wins.
  assign refresh_rep = repeat_in && !code_valid_in;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    rpt_d     = rpt_q;
    cmd_d     = cmd_q;
    pend_d    = pend_q;
    press_d   = 1'b0;
    repeat_d  = 1'b0;
    release_d = 1'b0;
    err_d     = 2'b00;
    err_cnt_d = err_cnt_q;

    if (frame_bad) begin
      err_d = inv_ok ? 2'b10 : 2'b01;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_ok) begin
          cmd_d   = frame_cmd;
          press_d = 1'b1;
          hold_d  = HOLD_LD;
          rpt_d   = DELAY_LD;
          state_d = S_HELD;
        end
      end

      S_HELD, S_REPEATING: begin
        if (frame_ok && frame_cmd != cmd_q) begin
          // Different key: end the old one now, start the new one next cycle.
          release_d = 1'b1;
          pend_d    = frame_cmd;
          state_d   = S_SWITCH;
        end else if (!(frame_ok || refresh_rep) && hold_q == '0) begin
          // Release beats a repeat that falls due on the same cycle.
          release_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          // Refresh reloads only the hold timer; cadence keeps running.
          hold_d = (frame_ok || refresh_rep) ? HOLD_LD : hold_q - HW'(1);
          if (rpt_q == '0) begin
            repeat_d = 1'b1;
            rpt_d    = PER_LD;
            state_d  = S_REPEATING;
          end else begin
            rpt_d = rpt_q - RW'(1);
          end
        end
      end

      S_SWITCH: begin
        cmd_d   = pend_q;
        press_d = 1'b1;
        hold_d  = HOLD_LD;
        rpt_d   = DELAY_LD;
        state_d = S_HELD;
      end

      default: state_d = S_IDLE;
    endcase

    held_d = (state_d == S_HELD) || (state_d == S_REPEATING);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      hold_q    <= '0;
      rpt_q     <= '0;
      cmd_q     <= 8'h00;
      pend_q    <= 8'h00;
      press_q   <= 1'b0;
      repeat_q  <= 1'b0;
      release_q <= 1'b0;
      held_q    <= 1'b0;
      err_q     <= 2'b00;
      err_cnt_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      rpt_q     <= rpt_d;
      cmd_q     <= cmd_d;
      pend_q    <= pend_d;
      press_q   <= press_d;
      repeat_q  <= repeat_d;
      release_q <= release_d;
      held_q    <= held_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign cmd_out       = cmd_q;
  assign press_out     = press_q;
  assign repeat_out    = repeat_q;
  assign release_out   = release_q;
  assign held_out      = held_q;
  assign err_out       = err_q;
  assign err_count_out = err_cnt_q;

endmodule

// File: tb/tb_ir_button_events.sv
// Bench for ir_button_events with HOLD=20, DELAY=10, PERIOD=4.
// Expected pulse events (cycle, pulse vector, cmd_out) are queued as stimulus
// is driven and popped as each cycle's outputs are sampled.
module tb_ir_button_events;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] code_in;
  logic        code_valid_in;
  logic        repeat_in;
  logic [7:0]  cmd_out;
  logic        press_out, repeat_out, release_out, held_out;
  logic [1:0]  err_out;
  logic [7:0]  err_count_out;

  ir_button_events #(
    .ADDRESS(8'h00), .HOLD_CYCLES(20), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .code_in(code_in),
    .code_valid_in(code_valid_in), .repeat_in(repeat_in),
    .cmd_out(cmd_out), .press_out(press_out), .repeat_out(repeat_out),
    .release_out(release_out), .held_out(held_out),
    .err_out(err_out), .err_count_out(err_count_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // pulse vector {press, repeat, release, err[1:0]}
  localparam logic [4:0] EV_PRESS = 5'b10000;
  localparam logic [4:0] EV_RPT   = 5'b01000;
  localparam logic [4:0] EV_REL   = 5'b00100;
  localparam logic [4:0] EV_EINV  = 5'b00001;
  localparam logic [4:0] EV_EADR  = 5'b00010;

  typedef struct {
    int         cyc;
    logic [4:0] ev;
    logic [7:0] cmd;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  errcnt_m = 0;
  logic [7:0] last_cmd = 8'h00;

  task automatic push(input int c, input logic [4:0] ev, input logic [7:0] cmd);
    ev_t e;
    e.cyc = c; e.ev = ev; e.cmd = cmd;
    sb.push_back(e);
  endtask

  // Advance one cycle; the outputs of the current cycle are scored at negedge.
  task automatic cycle();
    ev_t e;
    logic [4:0] obs;
    @(negedge clk_in);
    obs = {press_out, repeat_out, release_out, err_out};
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      checks++; errors++;
      $display("FAIL missed_event: expected ev=%b cmd=%h at cycle %0d, not seen", e.ev, e.cmd, e.cyc);
    end
    checks++;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      if (obs !== e.ev || cmd_out !== e.cmd) begin
        errors++;
        $display("FAIL event @%0d: got ev=%b cmd=%h, want ev=%b cmd=%h", cyc, obs, cmd_out, e.ev, e.cmd);
      end
    end else if (obs !== 5'b0) begin
      errors++;
      $display("FAIL unexpected_event @%0d: got ev=%b cmd=%h, want none", cyc, obs, cmd_out);
    end
    @(posedge clk_in); #1;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) cycle();
  endtask

  task automatic send(input logic [31:0] c, input logic rep, output int t);
    code_in = c; code_valid_in = 1'b1; repeat_in = rep; t = cyc;
    cycle();
    code_valid_in = 1'b0; repeat_in = 1'b0;
  endtask

  task automatic pulse_repeat();
    repeat_in = 1'b1;
    cycle();
    repeat_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; code_in = '0; code_valid_in = 1'b0; repeat_in = 1'b0;
    @(posedge clk_in); #1;
    cycle(); cycle();
    rst_in = 1'b0;
    cycle();
    checks++;
    if ({cmd_out, held_out, err_count_out, press_out, repeat_out, release_out, err_out} !== '0) begin
      errors++;
      $display("FAIL reset_state: got cmd=%h held=%b cnt=%h pulses=%b%b%b err=%b, want all 0",
               cmd_out, held_out, err_count_out, press_out, repeat_out, release_out, err_out);
    end
  endtask

  task automatic test_single_press();
    int t;
    send(32'h00FF_45BA, 1'b0, t);
    push(t+1, EV_PRESS, 8'h45);
    push(t+11, EV_RPT, 8'h45); push(t+15, EV_RPT, 8'h45); push(t+19, EV_RPT, 8'h45);
    push(t+21, EV_REL, 8'h45);
    run_to(t+1);
    checks++;
    if (held_out !== 1'b1 || cmd_out !== 8'h45) begin
      errors++; $display("FAIL single_press_held: got held=%b cmd=%h, want 1 45", held_out, cmd_out);
    end
    run_to(t+20);
    checks++;
    if (held_out !== 1'b1) begin errors++; $display("FAIL single_held_before_rel: got %b want 1", held_out); end
    run_to(t+21);
    checks++;
    if (held_out !== 1'b0) begin errors++; $display("FAIL single_held_at_rel: got %b want 0", held_out); end
    run_to(t+25);
    last_cmd = 8'h45;
  endtask

  task automatic test_hold_extension();
    int t;
    send(32'h00FF_45BA, 1'b0, t);
    push(t+1, EV_PRESS, 8'h45);
    for (int k = 0; 11 + 4*k < 66; k++) push(t+11+4*k, EV_RPT, 8'h45);
    push(t+66, EV_REL, 8'h45);
    run_to(t+15); pulse_repeat();
    run_to(t+30); pulse_repeat();
    run_to(t+45); pulse_repeat();
    run_to(t+65);
    checks++;
    if (held_out !== 1'b1) begin errors++; $display("FAIL ext_held_before_rel: got %b want 1", held_out); end
    run_to(t+66);
    checks++;
    if (held_out !== 1'b0) begin errors++; $display("FAIL ext_held_at_rel: got %b want 0", held_out); end
    run_to(t+70);
  endtask

  task automatic test_bad_inverse();
    int t;
    send(32'h00FF_45BB, 1'b0, t);
    errcnt_m++;
    push(t+1, EV_EINV, last_cmd);
    run_to(t+1);
    checks++;
    if (err_count_out !== errcnt_m[7:0] || held_out !== 1'b0) begin
      errors++; $display("FAIL bad_inverse_cnt: got cnt=%h held=%b, want %h 0", err_count_out, held_out, errcnt_m[7:0]);
    end
    run_to(t+4);
  endtask

  task automatic test_bad_address();
    int t;
    send(32'h01FE_45BA, 1'b0, t);
    errcnt_m++;
    push(t+1, EV_EADR, last_cmd);
    run_to(t+1);
    checks++;
    if (err_count_out !== errcnt_m[7:0]) begin
      errors++; $display("FAIL bad_address_cnt: got %h want %h", err_count_out, errcnt_m[7:0]);
    end
    for (int i = 0; i < 256; i++) begin
      send(32'h01FE_45BA, 1'b0, t);
      if (errcnt_m < 255) errcnt_m++;
      push(t+1, EV_EADR, last_cmd);
    end
    run_to(t+2);
    checks++;
    if (err_count_out !== 8'hFF || held_out !== 1'b0) begin
      errors++; $display("FAIL err_count_saturate: got cnt=%h held=%b, want FF 0", err_count_out, held_out);
    end
    run_to(t+4);
  endtask

  task automatic test_key_switch();
    int t, u, p;
    send(32'h00FF_45BA, 1'b0, t);
    push(t+1, EV_PRESS, 8'h45);
    run_to(t+5);
    send(32'h00FF_46B9, 1'b0, u);
    p = u + 2;
    push(u+1, EV_REL, 8'h45);
    push(p, EV_PRESS, 8'h46);
    push(p+10, EV_RPT, 8'h46); push(p+14, EV_RPT, 8'h46); push(p+18, EV_RPT, 8'h46);
    push(p+20, EV_REL, 8'h46);
    run_to(u+1);
    checks++;
    if (cmd_out !== 8'h45) begin errors++; $display("FAIL switch_old_cmd: got %h want 45", cmd_out); end
    run_to(p);
    checks++;
    if (cmd_out !== 8'h46 || held_out !== 1'b1) begin
      errors++; $display("FAIL switch_new_key: got cmd=%h held=%b, want 46 1", cmd_out, held_out);
    end
    run_to(p+24);
    last_cmd = 8'h46;
  endtask

  // Refresh on the very cycle the hold timer reaches zero keeps the key.
  task automatic test_refresh_at_expiry();
    int t;
    send(32'h00FF_45BA, 1'b0, t);
    push(t+1, EV_PRESS, 8'h45);
    for (int k = 0; 11 + 4*k < 41; k++) push(t+11+4*k, EV_RPT, 8'h45);
    push(t+41, EV_REL, 8'h45);
    run_to(t+20); pulse_repeat();
    run_to(t+21);
    checks++;
    if (held_out !== 1'b1) begin errors++; $display("FAIL refresh_at_expiry_held: got %b want 1", held_out); end
    run_to(t+45);
    last_cmd = 8'h45;
  endtask

  // Release lands on a cycle where a repeat is also due; only release fires.
  task automatic test_release_vs_repeat();
    int t;
    send(32'h00FF_45BA, 1'b0, t);
    push(t+1, EV_PRESS, 8'h45);
    push(t+11, EV_RPT, 8'h45); push(t+15, EV_RPT, 8'h45); push(t+19, EV_RPT, 8'h45);
    push(t+23, EV_REL, 8'h45);
    run_to(t+2); pulse_repeat();
    run_to(t+28);
  endtask

  task automatic test_reset_mid();
    int t;
    send(32'h00FF_45BA, 1'b0, t);
    push(t+1, EV_PRESS, 8'h45);
    push(t+11, EV_RPT, 8'h45);
    run_to(t+13);
    rst_in = 1'b1;
    cycle();
    rst_in = 1'b0;
    errcnt_m = 0; last_cmd = 8'h00;
    checks++;
    if ({cmd_out, held_out, err_count_out, press_out, repeat_out, release_out, err_out} !== '0) begin
      errors++;
      $display("FAIL reset_mid_hold: got cmd=%h held=%b cnt=%h pulses=%b%b%b err=%b, want all 0",
               cmd_out, held_out, err_count_out, press_out, repeat_out, release_out, err_out);
    end
    run_to(t+40);
  endtask

  task automatic test_simultaneous();
    int t;
    send(32'h00FF_45BA, 1'b1, t);
    push(t+1, EV_PRESS, 8'h45);
    push(t+11, EV_RPT, 8'h45); push(t+15, EV_RPT, 8'h45); push(t+19, EV_RPT, 8'h45);
    push(t+21, EV_REL, 8'h45);
    run_to(t+25);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_hold_extension();
    test_bad_inverse();
    test_bad_address();
    test_key_switch();
    test_refresh_at_expiry();
    test_release_vs_repeat();
    test_reset_mid();
    test_simultaneous();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
